jt49_dly_arb: RTL and testbench

JT49_DLY_ARB -- requirements
Module: jt49_dly_arb

---
 rtl/jt49_dly_arb_pkg.sv | 25 ++
 rtl/jt49_dly_ram.sv | 32 +++
 rtl/jt49_dly_arb.sv | 166 ++++++++++++++++
 tb/tb_jt49_dly_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/jt49_dly_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt49_dly_arb_pkg : shared FSM encoding and channel indices           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package jt49_dly_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_CH_A   = 2'd0;
  localparam logic [1:0] c_CH_B   = 2'd1;
  localparam logic [1:0] c_CH_C   = 2'd2;
  localparam int         c_NUM_CH = 3;

  function automatic logic is_last_ch(input logic [1:0] ch);
    return ch == 2'(c_NUM_CH - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt49_dly_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt49_dly_ram : single-port synchronous RAM, registered read          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jt49_dly_ram
  import jt49_dly_arb_pkg::*;
#(
  parameter int dw = 8,
  parameter int aw = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [aw-1:0] i_addr,
  input  logic [dw-1:0] i_wdata,
  output logic [dw-1:0] o_rdata
);

  logic [dw-1:0] r_mem [2**aw];
  logic [dw-1:0] r_rdata;

  // No reset on the array; stale words are masked by the warm-up logic upstream.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/jt49_dly_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jt49_dly_arb : three-channel sample delay sharing one single-port RAM|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module jt49_dly_arb
  import jt49_dly_arb_pkg::*;
#(
  parameter int dw    = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [dw-1:0]    din_a,
  input  logic [dw-1:0]    din_b,
  input  logic [dw-1:0]    din_c,
  input  logic [depth-1:0] dly_a,
  input  logic [depth-1:0] dly_b,
  input  logic [depth-1:0] dly_c,
  input  logic             ovr_clr,
  output logic [dw-1:0]    dout_a,
  output logic [dw-1:0]    dout_b,
  output logic [dw-1:0]    dout_c,
  output logic             dout_vld,
  output logic             busy,
  output logic             ovr
);

  state_t           r_state;
  logic [1:0]       r_ch;
  logic [depth-1:0] r_wrpos;
  logic [depth-1:0] r_fill;
  logic [dw-1:0]    r_din_a, r_din_b, r_din_c;
  logic [depth-1:0] r_dly_a, r_dly_b, r_dly_c;
  logic [dw-1:0]    r_stg_a, r_stg_b, r_stg_c;
  logic [dw-1:0]    r_dout_a, r_dout_b, r_dout_c;
  logic             r_vld;
  logic             r_ovr;

  logic [dw-1:0]    w_cur_din;
  logic [depth-1:0] w_cur_dly;
  logic [depth-1:0] w_pos;
  logic [depth+1:0] w_addr;
  logic [dw-1:0]    w_rdata;
  logic [dw-1:0]    w_stg_next;
  logic             w_we;
  logic             w_re;

  always_comb begin
    w_cur_din = '0;
    w_cur_dly = '0;
    case (r_ch)
      c_CH_A:  begin w_cur_din = r_din_a; w_cur_dly = r_dly_a; end
      c_CH_B:  begin w_cur_din = r_din_b; w_cur_dly = r_dly_b; end
      c_CH_C:  begin w_cur_din = r_din_c; w_cur_dly = r_dly_c; end
      default: begin w_cur_din = '0;      w_cur_dly = '0;      end
    endcase
  end

  // Read position wraps modulo the region size through natural overflow.
  assign w_pos  = (r_state == ST_WR) ? r_wrpos : (r_wrpos - w_cur_dly);
  assign w_addr = {r_ch, w_pos};
  assign w_we   = (r_state == ST_WR);
  assign w_re   = (r_state == ST_RD);

  // Zero delay bypasses the RAM; positions not yet written since reset read as 0.
  always_comb begin
    w_stg_next = w_rdata;
    if (w_cur_dly == '0)
      w_stg_next = w_cur_din;
    else if (r_fill < w_cur_dly)
      w_stg_next = '0;
  end

  jt49_dly_ram #(
    .dw (dw),
    .aw (depth + 2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_cur_din),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ch     <= c_CH_A;
      r_wrpos  <= '0;
      r_fill   <= '0;
      r_din_a  <= '0;
      r_din_b  <= '0;
      r_din_c  <= '0;
      r_dly_a  <= '0;
      r_dly_b  <= '0;
      r_dly_c  <= '0;
      r_stg_a  <= '0;
      r_stg_b  <= '0;
      r_stg_c  <= '0;
      r_dout_a <= '0;
      r_dout_b <= '0;
      r_dout_c <= '0;
      r_vld    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      // A new overrun takes priority over a clear in the same cycle.
      if (cen && (r_state != ST_IDLE))
        r_ovr <= 1'b1;
      else if (ovr_clr)
        r_ovr <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cen) begin
            r_din_a <= din_a;
            r_din_b <= din_b;
            r_din_c <= din_c;
            r_dly_a <= dly_a;
            r_dly_b <= dly_b;
            r_dly_c <= dly_c;
            r_ch    <= c_CH_A;
            r_state <= ST_RD;
          end
        end
        ST_RD: r_state <= ST_WR;
        ST_WR: begin
          case (r_ch)
            c_CH_A:  r_stg_a <= w_stg_next;
            c_CH_B:  r_stg_b <= w_stg_next;
            c_CH_C:  r_stg_c <= w_stg_next;
            default: ;
          endcase
          if (is_last_ch(r_ch)) begin
            r_state <= ST_DONE;
          end else begin
            r_ch    <= r_ch + 2'd1;
            r_state <= ST_RD;
          end
        end
        ST_DONE: begin
          r_dout_a <= r_stg_a;
          r_dout_b <= r_stg_b;
          r_dout_c <= r_stg_c;
          r_vld    <= 1'b1;
          r_wrpos  <= r_wrpos + depth'(1);
          if (r_fill != '1) r_fill <= r_fill + depth'(1);
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout_a   = r_dout_a;
  assign dout_b   = r_dout_b;
  assign dout_c   = r_dout_c;
  assign dout_vld = r_vld;
  assign busy     = (r_state != ST_IDLE);
  assign ovr      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_jt49_dly_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jt49_dly_arb : scoreboard bench for the shared-RAM delay block    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_jt49_dly_arb;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cen = 1'b0;
  logic [DW-1:0]    din_a = '0, din_b = '0, din_c = '0;
  logic [DEPTH-1:0] dly_a = '0, dly_b = '0, dly_c = '0;
  logic             ovr_clr = 1'b0;
  logic [DW-1:0]    dout_a, dout_b, dout_c;
  logic             dout_vld, busy, ovr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] sb_q [$];
  logic [7:0]  hist [3][256];
  int          n_samp = 0;

  jt49_dly_arb #(.dw(DW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .din_a(din_a), .din_b(din_b), .din_c(din_c),
    .dly_a(dly_a), .dly_b(dly_b), .dly_c(dly_c),
    .ovr_clr(ovr_clr),
    .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c),
    .dout_vld(dout_vld), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: delayed sample n-d, zero until d samples have been seen since reset.
  function automatic logic [7:0] exp_ch(input int ch, input int d, input logic [7:0] din);
    if (d == 0) return din;
    if (n_samp < d) return 8'h00;
    return hist[ch][n_samp - d];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] ea, eb, ec;
    din_a = a; din_b = b; din_c = c;
    ea = exp_ch(0, int'(dly_a), a);
    eb = exp_ch(1, int'(dly_b), b);
    ec = exp_ch(2, int'(dly_c), c);
    sb_q.push_back({ea, eb, ec});
    hist[0][n_samp] = a; hist[1][n_samp] = b; hist[2][n_samp] = c;
    n_samp++;
    cen = 1'b1;
    tick();
    cen = 1'b0;
  endtask

  task automatic sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, b, c);
    idle(9);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    n_samp = 0;
    idle(2);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && dout_vld) begin
      if (sb_q.size() == 0) begin
        check("vld_extra", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = sb_q.pop_front();
        check("dout_a", 32'(dout_a), 32'(e[23:16]));
        check("dout_b", 32'(dout_b), 32'(e[15:8]));
        check("dout_c", 32'(dout_c), 32'(e[7:0]));
      end
    end
  end

  initial begin
    logic [7:0] r;
    idle(2);
    rst = 1'b0;
    check("rst_dout_a", 32'(dout_a), 0);
    check("rst_dout_b", 32'(dout_b), 0);
    check("rst_dout_c", 32'(dout_c), 0);
    check("rst_vld",    32'(dout_vld), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_ovr",    32'(ovr), 0);

    // Single sample: latency and busy window.
    dly_a = 4'd3; dly_b = 4'd0; dly_c = 4'd15;
    send(8'h55, 8'h66, 8'h77);
    check("busy_t1", 32'(busy), 1);
    for (int i = 2; i <= 7; i++) begin
      tick();
      check("busy_seq", 32'(busy), 1);
      check("vld_early", 32'(dout_vld), 0);
    end
    tick();
    check("busy_t8", 32'(busy), 0);
    check("vld_t8", 32'(dout_vld), 1);
    tick();
    check("vld_t9", 32'(dout_vld), 0);
    idle(3);

    // Delay ramp with warm-up masking.
    do_reset();
    for (int k = 1; k <= 20; k++) sample(8'(k), 8'(k), 8'(k));

    // Overrun: second cen four cycles in.
    send(8'h21, 8'h22, 8'h23);
    idle(3);
    check("ovr_pre", 32'(ovr), 0);
    cen = 1'b1;
    tick();
    cen = 1'b0;
    check("ovr_set", 32'(ovr), 1);
    check("ovr_busy", 32'(busy), 1);
    idle(8);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", 32'(ovr), 0);
    send(8'h31, 8'h32, 8'h33);
    idle(1);
    cen = 1'b1; ovr_clr = 1'b1;
    tick();
    cen = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", 32'(ovr), 1);
    idle(8);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr2", 32'(ovr), 0);

    // Wrap twice with one-sample delay on A.
    do_reset();
    dly_a = 4'd1; dly_b = 4'd0; dly_c = 4'd15;
    for (int k = 0; k < 40; k++) begin
      r = 8'($urandom_range(1, 255));
      sample(r, 8'(k), 8'(~k));
    end

    // Reset in the middle of a sequence.
    do_reset();
    dly_a = 4'd3;
    for (int k = 1; k <= 4; k++) sample(8'(k + 8'h40), 8'(k + 8'h50), 8'(k));
    send(8'h99, 8'h98, 8'h97);
    idle(3);
    rst = 1'b1;
    sb_q.delete();
    n_samp = 0;
    tick();
    rst = 1'b0;
    check("mid_rst_a", 32'(dout_a), 0);
    check("mid_rst_b", 32'(dout_b), 0);
    check("mid_rst_busy", 32'(busy), 0);
    idle(10);
    sample(8'h11, 8'h12, 8'h13);
    check("post_rst_a", 32'(dout_a), 0);

    // Delay change mid-sequence applies from the next sample.
    dly_a = 4'd5;
    for (int k = 1; k <= 6; k++) sample(8'(k + 8'h60), 8'h01, 8'h02);
    send(8'h70, 8'h71, 8'h72);
    idle(2);
    dly_a = 4'd2; din_a = 8'hEE;
    idle(7);
    sample(8'h80, 8'h81, 8'h82);
    sample(8'h90, 8'h91, 8'h92);

    idle(5);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
